// File: rtl/booth_arb_pkg.sv
// rtl/booth_arb_pkg.sv - shared types and constants for the Booth multiplier arbiter
package booth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int DEF_W     = 3;
    localparam int DEF_RES_W = 2 * DEF_W;
    localparam int OPCNT_W   = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/booth_rr_arbiter.sv
// rtl/booth_rr_arbiter.sv - combinational round-robin grant starting after last_grant
module booth_rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IW-1:0]    last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    grant_idx_o,
    output logic             any_o
);

    logic [IW-1:0] cand_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IW'((int'(last_grant_i) + k) % N_REQ);
            if (!any_o && req_valid_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - shares one Booth multiplier among N_REQ requesters
// Optional WAIT-state timeout enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = DEF_W
`ifdef BOOTH_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*W-1:0]            req_a,
    input  logic [N_REQ*W-1:0]            req_b,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [idx_width(N_REQ)-1:0]   rsp_id,
    output logic [2*W-1:0]                rsp_result,
    output logic                          rsp_err,
    output logic                          mul_start,
    output logic [W-1:0]                  mul_a,
    output logic [W-1:0]                  mul_b,
    input  logic [2*W-1:0]                mul_resultado,
    input  logic                          mul_fin,
    output logic [OPCNT_W-1:0]            op_count
);

    localparam int IW = idx_width(N_REQ);
    localparam int RW = 2 * W;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       id_q, id_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [RW-1:0]       result_q, result_d;
    logic [OPCNT_W-1:0]  op_count_q, op_count_d;
    logic                first_wait_q, first_wait_d;
    logic                fin_ok;
    logic                mul_active;

    logic [N_REQ-1:0]    grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_any;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
`endif

    booth_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_o        (grant_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            op_count_q   <= '0;
            first_wait_q <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            op_count_q   <= op_count_d;
            first_wait_q <= first_wait_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        op_count_d   = op_count_q;
        first_wait_d = first_wait_q;
        fin_ok       = 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    a_d     = req_a[grant_idx*W +: W];
                    b_d     = req_b[grant_idx*W +: W];
                    id_d    = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                first_wait_d = 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
                tmo_d        = '0;
`endif
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // The multiplier may still show fin from the previous operation here.
                first_wait_d = 1'b0;
                fin_ok       = !first_wait_q && mul_fin;
                if (fin_ok) begin
                    result_d = mul_resultado;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ST_RESP;
                end
`ifdef BOOTH_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d    = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    op_count_d   = op_count_q + 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mul_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign req_ready  = (state_q == ST_IDLE) ? grant : '0;
    assign mul_start  = (state_q == ST_ISSUE);
    assign mul_a      = mul_active ? a_q : '0;
    assign mul_b      = mul_active ? b_q : '0;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign op_count   = op_count_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - scoreboard bench for booth_mult_arbiter with a behavioural multiplier
module tb_booth_mult_arbiter;
    import booth_arb_pkg::*;

    localparam int N  = 2;
    localparam int W  = DEF_W;
    localparam int RW = DEF_RES_W;

    typedef struct packed {
        logic [0:0]    id;
        logic [RW-1:0] res;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*W-1:0]    req_a = '0;
    logic [N*W-1:0]    req_b = '0;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [0:0]        rsp_id;
    logic [RW-1:0]     rsp_result;
    logic              rsp_err;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [RW-1:0]     mul_resultado = '0;
    logic              mul_fin = 1'b0;
    logic [15:0]       op_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t          sb[$];
    logic [2*W-1:0] q0[$];
    logic [2*W-1:0] q1[$];
    int            starts[$];
    logic [N-1:0]  acc = '0;
    exp_t          e;

    int  mul_lat    = 1;
    bit  stale_mode = 1'b0;
    bit  never_fin  = 1'b0;
    logic signed [W-1:0]  ma = '0, mb = '0;
    logic signed [RW-1:0] mae, mbe;
    int  mcnt  = 0;
    bit  mbusy = 1'b0;
    bit  mstale = 1'b0;

    booth_mult_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_err       (rsp_err),
        .mul_start     (mul_start),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_resultado (mul_resultado),
        .mul_fin       (mul_fin),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: fin stays high until the next start (or one cycle later in stale mode).
    assign mae = ma;
    assign mbe = mb;
    always @(posedge clk) begin
        if (mul_start) begin
            ma     <= mul_a;
            mb     <= mul_b;
            mcnt   <= 0;
            mbusy  <= 1'b1;
            mstale <= stale_mode;
            if (!stale_mode) mul_fin <= 1'b0;
        end else if (mbusy) begin
            if (mstale) begin
                mul_fin <= 1'b0;
                mstale  <= 1'b0;
            end
            mcnt <= mcnt + 1;
            if (!never_fin && (mcnt + 1 >= mul_lat)) begin
                mul_fin       <= 1'b1;
                mul_resultado <= mae * mbe;
                mbusy         <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (!$onehot0(req_ready))
                $display("FAIL req_ready_onehot actual=%b required=at most one bit", req_ready);
            else
                n_pass++;
            if (mul_start) starts.push_back(cyc);
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected actual id=%0d result=%h required=no response", rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err})
                        $display("FAIL rsp_data actual id=%0d result=%h err=%b required id=%0d result=%h err=%b",
                                 rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
                    else
                        n_pass++;
                end
            end
            acc = req_valid & req_ready;
        end else begin
            acc = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        req_valid[0] = (q0.size() > 0);
        req_valid[1] = (q1.size() > 0);
        if (q0.size() > 0) {req_a[W-1:0], req_b[W-1:0]} = q0[0];
        if (q1.size() > 0) {req_a[2*W-1:W], req_b[2*W-1:W]} = q1[0];
    end

    task automatic push_exp(input logic id, input logic [RW-1:0] res, input logic err);
        exp_t x;
        x.id  = id;
        x.res = res;
        x.err = err;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_checks++;
        if (k >= budget)
            $display("FAIL %s_drain actual=%0d responses outstanding required=0 within %0d cycles", name, sb.size(), budget);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, mul_start} !== 3'b000)
            $display("FAIL reset_ctrl actual=%b required=000", {rsp_valid, rsp_err, mul_start});
        else n_pass++;
        n_checks++;
        if ({rsp_id, rsp_result} !== '0)
            $display("FAIL reset_rsp actual id=%0d result=%h required=0", rsp_id, rsp_result);
        else n_pass++;
        n_checks++;
        if ({mul_a, mul_b} !== '0)
            $display("FAIL reset_mul_ops actual=%h required=0", {mul_a, mul_b});
        else n_pass++;
        n_checks++;
        if (req_ready !== '0)
            $display("FAIL reset_req_ready actual=%b required=00", req_ready);
        else n_pass++;
        n_checks++;
        if (op_count !== 16'd0)
            $display("FAIL reset_op_count actual=%0d required=0", op_count);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_op();
        starts.delete();
        q0.push_back({3'd3, 3'b110});
        push_exp(1'b0, 6'b111010, 1'b0);
        wait_drain("single_op", 40);
        n_checks++;
        if (starts.size() != 1)
            $display("FAIL single_start_pulses actual=%0d required=1", starts.size());
        else n_pass++;
        n_checks++;
        if (op_count !== 16'd1)
            $display("FAIL single_op_count actual=%0d required=1", op_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int k = 0;
        rsp_ready = 1'b0;
        starts.delete();
        q0.push_back({3'b111, 3'd2});
        push_exp(1'b0, 6'b111110, 1'b0);
        while (!rsp_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!rsp_valid)
            $display("FAIL bp_rsp_valid actual=0 required=1 within 30 cycles");
        else n_pass++;
        q1.push_back({3'd3, 3'd2});
        push_exp(1'b1, 6'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready, mul_start} !== {1'b1, 1'b0, 6'b111110, 2'b00, 1'b0})
                $display("FAIL bp_hold cycle=%0d actual valid=%b id=%0d result=%h ready=%b start=%b required valid=1 id=0 result=3e ready=00 start=0",
                         i, rsp_valid, rsp_id, rsp_result, req_ready, mul_start);
            else n_pass++;
        end
        n_checks++;
        if (starts.size() != 1)
            $display("FAIL bp_no_issue actual=%0d starts required=1", starts.size());
        else n_pass++;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_drain("backpressure", 60);
        n_checks++;
        if (op_count !== 16'd3)
            $display("FAIL bp_op_count actual=%0d required=3", op_count);
        else n_pass++;
    endtask

    task automatic test_contention();
        starts.delete();
        q0.push_back({3'd2, 3'd3});
        q0.push_back({3'b100, 3'b100});
        q1.push_back({3'd1, 3'b111});
        q1.push_back({3'd3, 3'd3});
        push_exp(1'b0, 6'd6, 1'b0);
        push_exp(1'b1, 6'b111111, 1'b0);
        push_exp(1'b0, 6'd16, 1'b0);
        push_exp(1'b1, 6'd9, 1'b0);
        wait_drain("contention", 100);
        n_checks++;
        if (starts.size() != 4)
            $display("FAIL cont_starts actual=%0d required=4", starts.size());
        else n_pass++;
        for (int i = 1; i < starts.size(); i++) begin
            n_checks++;
            if (starts[i] - starts[i-1] != 5)
                $display("FAIL cont_issue_spacing op=%0d actual=%0d required=5", i, starts[i] - starts[i-1]);
            else n_pass++;
        end
        n_checks++;
        if (op_count !== 16'd7)
            $display("FAIL cont_op_count actual=%0d required=7", op_count);
        else n_pass++;
    endtask

    task automatic test_stale_fin();
        stale_mode = 1'b1;
        mul_lat    = 3;
        q1.push_back({3'b111, 3'd3});
        push_exp(1'b1, 6'b111101, 1'b0);
        wait_drain("stale_fin", 60);
        n_checks++;
        if (op_count !== 16'd8)
            $display("FAIL stale_op_count actual=%0d required=8", op_count);
        else n_pass++;
        stale_mode = 1'b0;
        mul_lat    = 1;
    endtask

    task automatic test_reset_mid_wait();
        int k = 0;
        mul_lat = 8;
        q0.push_back({3'd1, 3'd1});
        push_exp(1'b0, 6'd1, 1'b0);
        wait_drain("pre_abort", 60);
        starts.delete();
        q1.push_back({3'd2, 3'd2});
        while (starts.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (starts.size() == 0)
            $display("FAIL abort_issue actual=no start required=start within 20 cycles");
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, mul_start, req_ready, mul_a, mul_b, rsp_result} !== '0)
            $display("FAIL mid_reset_outputs actual valid=%b start=%b ready=%b a=%h b=%h result=%h required=all 0",
                     rsp_valid, mul_start, req_ready, mul_a, mul_b, rsp_result);
        else n_pass++;
        n_checks++;
        if (op_count !== 16'd0)
            $display("FAIL mid_reset_op_count actual=%0d required=0", op_count);
        else n_pass++;
        reset   = 1'b0;
        mul_lat = 2;
        q0.push_back({3'd3, 3'd1});
        q1.push_back({3'b110, 3'd3});
        push_exp(1'b0, 6'd3, 1'b0);
        push_exp(1'b1, 6'b111010, 1'b0);
        wait_drain("post_reset", 60);
        n_checks++;
        if (op_count !== 16'd2)
            $display("FAIL post_reset_op_count actual=%0d required=2", op_count);
        else n_pass++;
        mul_lat = 1;
    endtask

`ifdef BOOTH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        never_fin = 1'b1;
        starts.delete();
        q0.push_back({3'd1, 3'd1});
        push_exp(1'b0, 6'd0, 1'b1);
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!rsp_valid || starts.size() != 1 || (cyc - starts[0]) != 17)
            $display("FAIL timeout_latency actual valid=%b starts=%0d cycles=%0d required valid=1 starts=1 cycles=17",
                     rsp_valid, starts.size(), (starts.size() > 0) ? cyc - starts[0] : -1);
        else n_pass++;
        wait_drain("timeout", 40);
        n_checks++;
        if (op_count !== 16'd3)
            $display("FAIL timeout_op_count actual=%0d required=3", op_count);
        else n_pass++;
        never_fin = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_contention();
        test_stale_fin();
        test_reset_mid_wait();
`ifdef BOOTH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
